registerunit_pipe: RTL and testbench

Parametrised successor to the single-cycle register unit for the pipelined core. It holds `NREGS` architectural registers of `XLEN` bits, with x0 hard-wired to zero, two combinational read ports and one synchronous write port. It adds a per-register busy scoreboard: issue marks a destination pending and writeback clears it, so decode can detect RAW hazards. An optional same-cycle write-to-read bypass is available.

---
 rtl/registerunit_pipe.sv | 102 ++++++++++
 tb/tb_registerunit_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/registerunit_pipe.sv
// Pipelined register unit: NREGS x XLEN registers (x0 reads as zero), two
// combinational read ports, one write port and a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding: define REGUNIT_BYPASS_EN.
module registerunit_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] ru1,
  output logic [XLEN-1:0] ru2,
  output logic            busy1,
  output logic            busy2,
  output logic            hazard,
  input  logic            RuWr,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] RuWrData,
  input  logic            IssueEn,
  input  logic [AW-1:0]   IssueRd,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:1] busy;
  logic [NREGS-1:1] busy_nxt;
  logic [AW:0]      cnt_nxt;

  // Issue is applied after writeback so a same-edge reissue keeps the bit set.
  // NOTE: every always_comb output gets a default first; otherwise a path that
  // skips an assignment infers a latch.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    if (RuWr && rd != '0)
      busy_nxt[rd] = 1'b0;
    if (IssueEn && IssueRd != '0)
      busy_nxt[IssueRd] = 1'b1;
    for (int r = 1; r < NREGS; r++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
  end

  // NOTE: the register array is reset because architectural state must read
  // as zero after reset; that rules out plain RAM inference for this array.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREGS; r++)
        regs[r] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (RuWr && rd != '0)
        regs[rd] <= RuWrData;
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

`ifdef REGUNIT_BYPASS_EN
  logic wr_live;
  logic reissue;
  assign wr_live = RuWr && rd != '0;
  assign reissue = IssueEn && IssueRd == rd;
`endif

  // Outputs are forced low while rst is high so forwarding cannot leak inputs.
  always_comb begin
    ru1   = '0;
    ru2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (!rst) begin
      if (rs1 != '0) begin
        ru1   = regs[rs1];
        busy1 = busy[rs1];
      end
      if (rs2 != '0) begin
        ru2   = regs[rs2];
        busy2 = busy[rs2];
      end
`ifdef REGUNIT_BYPASS_EN
      if (wr_live && rs1 == rd) begin
        ru1 = RuWrData;
        if (!reissue)
          busy1 = 1'b0;
      end
      if (wr_live && rs2 == rd) begin
        ru2 = RuWrData;
        if (!reissue)
          busy2 = 1'b0;
      end
`endif
    end
  end

  assign hazard = busy1 | busy2;

endmodule

// File: tb/tb_registerunit_pipe.sv
// Self-checking bench for registerunit_pipe: table vectors through a scoreboard
// queue, plus hand-written bypass, scoreboard-saturation and async-reset cases.
module tb_registerunit_pipe;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

`ifdef REGUNIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rs1, rs2, rd, IssueRd;
  logic [XLEN-1:0] ru1, ru2, RuWrData;
  logic            busy1, busy2, hazard, RuWr, IssueEn;
  logic [AW:0]     pend_cnt;

  registerunit_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ru1(ru1), .ru2(ru2),
    .busy1(busy1), .busy2(busy2), .hazard(hazard), .RuWr(RuWr), .rd(rd),
    .RuWrData(RuWrData), .IssueEn(IssueEn), .IssueRd(IssueRd), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs are those seen during the same cycle, before the edge
  // that commits this row's write/issue.
  typedef struct {
    logic [AW-1:0]   rs1, rs2;
    logic            wr;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wdata;
    logic            iss;
    logic [AW-1:0]   ird;
    logic [XLEN-1:0] e_ru1, e_ru2;
    logic            e_b1, e_b2, e_hz;
    logic [AW:0]     e_pend;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl [19];
  vec_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r1, input int r2, input bit w, input int d,
                              input logic [31:0] wd, input bit is, input int ir,
                              input logic [31:0] q1, input logic [31:0] q2,
                              input bit b1, input bit b2, input bit hz, input int pc);
    vec_t v;
    v.rs1 = AW'(r1); v.rs2 = AW'(r2); v.wr = w; v.rd = AW'(d); v.wdata = wd;
    v.iss = is; v.ird = AW'(ir); v.e_ru1 = q1; v.e_ru2 = q2;
    v.e_b1 = b1; v.e_b2 = b2; v.e_hz = hz; v.e_pend = (AW+1)'(pc);
    return v;
  endfunction

  task automatic idle();
    RuWr = 1'b0; rd = '0; RuWrData = '0; IssueEn = 1'b0; IssueRd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t v;
      v = exp_q.pop_front();
      check("tbl_ru1",  {32'h0, ru1},      {32'h0, v.e_ru1});
      check("tbl_ru2",  {32'h0, ru2},      {32'h0, v.e_ru2});
      check("tbl_busy1", {63'h0, busy1},   {63'h0, v.e_b1});
      check("tbl_busy2", {63'h0, busy2},   {63'h0, v.e_b2});
      check("tbl_hazard", {63'h0, hazard}, {63'h0, v.e_hz});
      check("tbl_pend", {58'h0, pend_cnt}, {58'h0, v.e_pend});
    end
  end

  initial begin
    //             rs1 rs2 wr rd  wdata          is ird  ru1            ru2           b1 b2 hz pend
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,          0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 32'h1234_5678,  1, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 2, 32'h1234_5678,  0, 0, 32'h0,         32'h0,         0, 0, 0, 0);
    tbl[3]  = mk(2, 0, 1, 1, 32'hA5A5_A5A5,  0, 0, 32'h1234_5678, 32'h0,         0, 0, 0, 0);
    tbl[4]  = mk(1, 2, 0, 0, 32'h0,          0, 0, 32'hA5A5_A5A5, 32'h1234_5678, 0, 0, 0, 0);
    tbl[5]  = mk(1, 3, 0, 0, 32'h0,          1, 7, 32'hA5A5_A5A5, 32'h0,         0, 0, 0, 0);
    tbl[6]  = mk(7, 0, 0, 0, 32'h0,          1, 8, 32'h0,         32'h0,         1, 0, 1, 1);
    tbl[7]  = mk(8, 0, 1, 7, 32'h0000_0042,  0, 0, 32'h0,         32'h0,         1, 0, 1, 2);
    tbl[8]  = mk(7, 8, 0, 0, 32'h0,          0, 0, 32'h42,        32'h0,         0, 1, 1, 1);
    tbl[9]  = mk(9, 8, 0, 0, 32'h0,          1, 9, 32'h0,         32'h0,         0, 1, 1, 1);
    tbl[10] = mk(8, 0, 1, 9, 32'h0000_0099,  1, 9, 32'h0,         32'h0,         1, 0, 1, 2);
    tbl[11] = mk(9, 8, 0, 0, 32'h0,          0, 0, 32'h99,        32'h0,         1, 1, 1, 2);
    tbl[12] = mk(9, 0, 1, 8, 32'h0000_0080,  0, 0, 32'h99,        32'h0,         1, 0, 1, 2);
    tbl[13] = mk(8, 0, 1, 3, 32'h0000_0033,  0, 0, 32'h80,        32'h0,         0, 0, 0, 1);
    tbl[14] = mk(3, 9, 0, 0, 32'h0,          0, 0, 32'h33,        32'h99,        0, 1, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 32'h0,          1, 9, 32'h0,         32'h0,         0, 0, 0, 1);
    tbl[16] = mk(3, 0, 1, 9, 32'h0000_0199,  0, 0, 32'h33,        32'h0,         0, 0, 0, 1);
    tbl[17] = mk(9, 0, 0, 0, 32'h0,          0, 0, 32'h199,       32'h0,         0, 0, 0, 0);
    tbl[18] = mk(0, 0, 1, 4, 32'h0000_0001,  0, 0, 32'h0,         32'h0,         0, 0, 0, 0);

    rst = 1'b1;
    idle();
    #12 rst = 1'b0;

    foreach (tbl[i]) begin
      step();
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      RuWr = tbl[i].wr; rd = tbl[i].rd; RuWrData = tbl[i].wdata;
      IssueEn = tbl[i].iss; IssueRd = tbl[i].ird;
      exp_q.push_back(tbl[i]);
    end

    // x4 now holds 1. Mark it busy, then write 2 while reading it on both ports.
    step(); idle(); IssueEn = 1'b1; IssueRd = 5'd4;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    step(); idle(); RuWr = 1'b1; rd = 5'd4; RuWrData = 32'h2; rs1 = 5'd4; rs2 = 5'd4;
    #2;
    check("byp_ru1",   {32'h0, ru1},    BYP ? 64'h2 : 64'h1);
    check("byp_ru2",   {32'h0, ru2},    BYP ? 64'h2 : 64'h1);
    check("byp_busy1", {63'h0, busy1},  BYP ? 64'h0 : 64'h1);
    check("byp_busy2", {63'h0, busy2},  BYP ? 64'h0 : 64'h1);
    step(); idle(); rs1 = 5'd4; rs2 = 5'd4;
    #2;
    check("post_ru1",   {32'h0, ru1},   64'h2);
    check("post_ru2",   {32'h0, ru2},   64'h2);
    check("post_busy1", {63'h0, busy1}, 64'h0);

    // Writeback and reissue of x6 in one cycle: the stored busy bit still shows.
    step(); idle(); IssueEn = 1'b1; IssueRd = 5'd6;
    step(); idle(); IssueEn = 1'b1; IssueRd = 5'd6; RuWr = 1'b1; rd = 5'd6;
    RuWrData = 32'h66; rs1 = 5'd6;
    #2;
    check("reiss_busy1", {63'h0, busy1}, 64'h1);
    check("reiss_ru1",   {32'h0, ru1},   BYP ? 64'h66 : 64'h0);
    step(); idle(); rs1 = 5'd6;
    #2;
    check("reiss_after_busy1", {63'h0, busy1},   64'h1);
    check("reiss_after_ru1",   {32'h0, ru1},     64'h66);
    check("reiss_after_pend",  {58'h0, pend_cnt}, 64'd1);

    // Saturate the scoreboard: every register except x0 busy.
    for (int r = 0; r < NREGS; r++) begin
      step(); idle(); IssueEn = 1'b1; IssueRd = AW'(r);
    end
    step(); idle(); rs1 = 5'd31;
    #2;
    check("full_pend",   {58'h0, pend_cnt}, 64'(NREGS - 1));
    check("full_hazard", {63'h0, hazard},   64'h1);

    // Load x5, then hit reset mid-write/mid-issue between edges.
    step(); idle(); RuWr = 1'b1; rd = 5'd5; RuWrData = 32'hDEAD_BEEF;
    IssueEn = 1'b1; IssueRd = 5'd5; rs1 = 5'd5; rs2 = 5'd5;
    step();
    #2;
    check("pre_rst_ru1",   {32'h0, ru1},      64'hDEAD_BEEF);
    check("pre_rst_busy1", {63'h0, busy1},    64'h1);
    check("pre_rst_pend",  {58'h0, pend_cnt}, 64'(NREGS - 1));
    #1 rst = 1'b1;
    #1;
    check("rst_ru1",    {32'h0, ru1},      64'h0);
    check("rst_ru2",    {32'h0, ru2},      64'h0);
    check("rst_busy1",  {63'h0, busy1},    64'h0);
    check("rst_hazard", {63'h0, hazard},   64'h0);
    check("rst_pend",   {58'h0, pend_cnt}, 64'h0);
    step();
    check("rst_hold_pend", {58'h0, pend_cnt}, 64'h0);
    check("rst_hold_ru1",  {32'h0, ru1},      64'h0);
    #2 rst = 1'b0;
    idle(); rs1 = 5'd5; rs2 = 5'd5;
    step();
    #2;
    check("after_rst_ru1",   {32'h0, ru1},      64'h0);
    check("after_rst_busy2", {63'h0, busy2},    64'h0);
    check("after_rst_pend",  {58'h0, pend_cnt}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
